// File: rtl/mc_control.sv
// mc_control: multicycle processor control FSM.
// Sequences fetch, decode, operand load, execute and memory phases, and
// handles interrupt entry, illegal opcodes and memory bus timeouts.
// All control outputs are Moore outputs of the state. They are held in a
// register that is loaded from the decode of the next state, so they always
// equal the decode of the current state.
module mc_control #(
   parameter int unsigned TIMEOUT = 15,
   parameter bit          IRQ_EN  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] op,
   input  logic [3:0] ext,
   input  logic       cond_p,
   input  logic       mem_ready,
   input  logic       irq,
   output logic       mem_rd_en,
   output logic       mem_wr_en,
   output logic       reg_file_wr_en,
   output logic       reg_file_a_rd_en,
   output logic       reg_file_b_rd_en,
   output logic       set_flags,
   output logic       imm_to_b,
   output logic [1:0] pc_op,
   output logic       pc_to_reg_file,
   output logic       mem_to_reg_file,
   output logic       mem_to_inst_reg,
   output logic       mem_to_decode,
   output logic       b_to_mem_addr,
   output logic       vector_to_pc,
   output logic       irq_ack,
   output logic       illegal_op,
   output logic       bus_fault
);

   localparam logic [3:0] OP_BCOND    = 4'b1100;
   localparam logic [3:0] OP_CMPI     = 4'b1011;
   localparam logic [3:0] OP_MOVI     = 4'b1101;
   localparam logic [3:0] OP_REGISTER = 4'b0000;
   localparam logic [3:0] OP_SHIFT    = 4'b1000;
   localparam logic [3:0] OP_SPECIAL  = 4'b0100;

   localparam logic [3:0] EXT_CMP     = 4'b1011;
   localparam logic [3:0] EXT_JCOND   = 4'b1100;
   localparam logic [3:0] EXT_JAL     = 4'b1000;
   localparam logic [3:0] EXT_LSH     = 4'b0100;
   localparam logic [3:0] EXT_LOAD    = 4'b0000;
   localparam logic [3:0] EXT_MOV     = 4'b1101;
   localparam logic [3:0] EXT_STORE   = 4'b0100;

   localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

   typedef enum logic [4:0] {
      FETCH           = 5'd0,
      DECODE          = 5'd1,
      LOAD_A_B        = 5'd2,
      LOAD_A          = 5'd3,
      LOAD_B          = 5'd4,
      IMM_ALU_OP      = 5'd5,
      ALU_OP          = 5'd6,
      ALU_FLAG_OP     = 5'd7,
      IMM_ALU_FLAG_OP = 5'd8,
      BRANCH          = 5'd9,
      LOAD_FROM_MEM   = 5'd10,
      MEM_TO_REG_FILE = 5'd11,
      STORE_TO_MEM    = 5'd12,
      JUMP            = 5'd13,
      JUMP_AND_LINK   = 5'd14,
      ILLEGAL         = 5'd15,
      IRQ_SAVE        = 5'd16,
      IRQ_VECTOR      = 5'd17,
      FAULT           = 5'd18
   } state_t;

   typedef struct packed {
      logic       mem_rd_en;
      logic       mem_wr_en;
      logic       reg_file_wr_en;
      logic       reg_file_a_rd_en;
      logic       reg_file_b_rd_en;
      logic       set_flags;
      logic       imm_to_b;
      logic [1:0] pc_op;
      logic       pc_to_reg_file;
      logic       mem_to_reg_file;
      logic       mem_to_inst_reg;
      logic       mem_to_decode;
      logic       b_to_mem_addr;
      logic       vector_to_pc;
      logic       irq_ack;
      logic       illegal_op;
      logic       bus_fault;
   } ctrl_t;

   // Moore output decode; unlisted outputs and unencoded states give all zeros.
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:           c.mem_rd_en = 1'b1;
         DECODE: begin
            c.mem_to_inst_reg = 1'b1;
            c.mem_to_decode   = 1'b1;
            c.pc_op           = 2'd1;
         end
         LOAD_A_B: begin
            c.reg_file_a_rd_en = 1'b1;
            c.reg_file_b_rd_en = 1'b1;
         end
         LOAD_A:          c.reg_file_a_rd_en = 1'b1;
         LOAD_B:          c.reg_file_b_rd_en = 1'b1;
         IMM_ALU_OP: begin
            c.imm_to_b       = 1'b1;
            c.set_flags      = 1'b1;
            c.reg_file_wr_en = 1'b1;
         end
         ALU_OP: begin
            c.set_flags      = 1'b1;
            c.reg_file_wr_en = 1'b1;
         end
         ALU_FLAG_OP:     c.set_flags = 1'b1;
         IMM_ALU_FLAG_OP: begin
            c.imm_to_b  = 1'b1;
            c.set_flags = 1'b1;
         end
         BRANCH: begin
            c.imm_to_b = 1'b1;
            c.pc_op    = 2'd2;
         end
         LOAD_FROM_MEM: begin
            c.b_to_mem_addr = 1'b1;
            c.mem_rd_en     = 1'b1;
         end
         MEM_TO_REG_FILE: begin
            c.mem_to_reg_file = 1'b1;
            c.reg_file_wr_en  = 1'b1;
         end
         STORE_TO_MEM: begin
            c.b_to_mem_addr = 1'b1;
            c.mem_wr_en     = 1'b1;
         end
         JUMP:            c.pc_op = 2'd3;
         JUMP_AND_LINK: begin
            c.pc_op          = 2'd3;
            c.pc_to_reg_file = 1'b1;
            c.reg_file_wr_en = 1'b1;
         end
         ILLEGAL:         c.illegal_op = 1'b1;
         IRQ_SAVE: begin
            c.pc_to_reg_file = 1'b1;
            c.reg_file_wr_en = 1'b1;
         end
         IRQ_VECTOR: begin
            c.vector_to_pc = 1'b1;
            c.pc_op        = 2'd3;
            c.irq_ack      = 1'b1;
         end
         FAULT:           c.bus_fault = 1'b1;
         default:         c = '0;
      endcase
      return c;
   endfunction

   state_t     state_r;
   state_t     state_s;
   state_t     end_s;
   logic [7:0] wait_cnt_r;
   logic [7:0] wait_cnt_s;
   logic       in_irq_r;
   logic       in_irq_s;
   logic       timeout_s;
   logic       mem_state_s;
   ctrl_t      ctrl_r;

   // Instruction end: take a pending interrupt unless one is already being serviced.
   always_comb begin
      end_s = FETCH;
      if ((IRQ_EN == 1'b1) && irq && !in_irq_r) begin
         end_s = IRQ_SAVE;
      end else begin
         end_s = FETCH;
      end
   end

   // Memory wait bookkeeping: this waiting cycle would bring the count to TIMEOUT.
   always_comb begin
      mem_state_s = (state_r == FETCH) || (state_r == LOAD_FROM_MEM) ||
                    (state_r == STORE_TO_MEM);
      timeout_s   = ((wait_cnt_r + 8'd1) >= TIMEOUT_C);
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         FETCH: begin
            if (mem_ready)      state_s = DECODE;
            else if (timeout_s) state_s = FAULT;
            else                state_s = FETCH;
         end
         DECODE: begin
            case (op)
               OP_BCOND:    state_s = cond_p ? BRANCH : end_s;
               OP_MOVI:     state_s = IMM_ALU_OP;
               OP_REGISTER: state_s = (ext == EXT_MOV) ? LOAD_B : LOAD_A_B;
               OP_SHIFT:    state_s = (ext == EXT_LSH) ? LOAD_A_B : LOAD_A;
               OP_SPECIAL: begin
                  case (ext)
                     EXT_JAL:   state_s = LOAD_B;
                     EXT_JCOND: state_s = cond_p ? LOAD_B : end_s;
                     EXT_LOAD:  state_s = LOAD_B;
                     EXT_STORE: state_s = LOAD_A_B;
                     default:   state_s = ILLEGAL;
                  endcase
               end
               default:     state_s = LOAD_A;
            endcase
         end
         LOAD_A_B: begin
            if (op == OP_SPECIAL)   state_s = STORE_TO_MEM;
            else if (ext == EXT_CMP) state_s = ALU_FLAG_OP;
            else                     state_s = ALU_OP;
         end
         LOAD_A: begin
            if (op == OP_CMPI) state_s = IMM_ALU_FLAG_OP;
            else               state_s = IMM_ALU_OP;
         end
         LOAD_B: begin
            if (op == OP_REGISTER) begin
               state_s = ALU_OP;
            end else begin
               case (ext)
                  EXT_JAL:   state_s = JUMP_AND_LINK;
                  EXT_JCOND: state_s = JUMP;
                  EXT_LOAD:  state_s = LOAD_FROM_MEM;
                  default:   state_s = end_s;
               endcase
            end
         end
         IMM_ALU_OP, ALU_OP, ALU_FLAG_OP, IMM_ALU_FLAG_OP, BRANCH,
         JUMP, JUMP_AND_LINK, MEM_TO_REG_FILE, ILLEGAL: begin
            state_s = end_s;
         end
         LOAD_FROM_MEM: begin
            if (mem_ready)      state_s = MEM_TO_REG_FILE;
            else if (timeout_s) state_s = FAULT;
            else                state_s = LOAD_FROM_MEM;
         end
         STORE_TO_MEM: begin
            if (mem_ready)      state_s = end_s;
            else if (timeout_s) state_s = FAULT;
            else                state_s = STORE_TO_MEM;
         end
         IRQ_SAVE:   state_s = IRQ_VECTOR;
         IRQ_VECTOR: state_s = FETCH;
         FAULT:      state_s = FAULT;
         default:    state_s = FETCH;
      endcase
   end

   // Wait counter restarts on any state change and counts unanswered memory cycles.
   always_comb begin
      wait_cnt_s = wait_cnt_r;
      if (state_s != state_r) begin
         wait_cnt_s = 8'd0;
      end else if (mem_state_s && !mem_ready) begin
         wait_cnt_s = wait_cnt_r + 8'd1;
      end else begin
         wait_cnt_s = wait_cnt_r;
      end
   end

   // Interrupt-in-service flag: set after vectoring, cleared around the return jump.
   always_comb begin
      in_irq_s = in_irq_r;
      if ((state_r == JUMP) || (state_s == JUMP)) begin
         in_irq_s = 1'b0;
      end else if (state_r == IRQ_VECTOR) begin
         in_irq_s = 1'b1;
      end else begin
         in_irq_s = in_irq_r;
      end
   end

   // State, counter, flag and output registers; everything holds while en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= FETCH;
         wait_cnt_r <= 8'd0;
         in_irq_r   <= 1'b0;
         ctrl_r     <= decode_ctrl(FETCH);
      end else if (en) begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         in_irq_r   <= in_irq_s;
         ctrl_r     <= decode_ctrl(state_s);
      end else begin
         state_r    <= state_r;
         wait_cnt_r <= wait_cnt_r;
         in_irq_r   <= in_irq_r;
         ctrl_r     <= ctrl_r;
      end
   end

   assign mem_rd_en        = ctrl_r.mem_rd_en;
   assign mem_wr_en        = ctrl_r.mem_wr_en;
   assign reg_file_wr_en   = ctrl_r.reg_file_wr_en;
   assign reg_file_a_rd_en = ctrl_r.reg_file_a_rd_en;
   assign reg_file_b_rd_en = ctrl_r.reg_file_b_rd_en;
   assign set_flags        = ctrl_r.set_flags;
   assign imm_to_b         = ctrl_r.imm_to_b;
   assign pc_op            = ctrl_r.pc_op;
   assign pc_to_reg_file   = ctrl_r.pc_to_reg_file;
   assign mem_to_reg_file  = ctrl_r.mem_to_reg_file;
   assign mem_to_inst_reg  = ctrl_r.mem_to_inst_reg;
   assign mem_to_decode    = ctrl_r.mem_to_decode;
   assign b_to_mem_addr    = ctrl_r.b_to_mem_addr;
   assign vector_to_pc     = ctrl_r.vector_to_pc;
   assign irq_ack          = ctrl_r.irq_ack;
   assign illegal_op       = ctrl_r.illegal_op;
   assign bus_fault        = ctrl_r.bus_fault;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed scoreboard bench for mc_control (TIMEOUT=4).
// The driver sets inputs just after a falling edge and queues the output
// vector expected after the next rising edge; the monitor pops and compares
// on every falling edge.
module tb_mc_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] op;
   logic [3:0] ext;
   logic       cond_p;
   logic       mem_ready;
   logic       irq;
   logic       mem_rd_en, mem_wr_en, reg_file_wr_en, reg_file_a_rd_en;
   logic       reg_file_b_rd_en, set_flags, imm_to_b;
   logic [1:0] pc_op;
   logic       pc_to_reg_file, mem_to_reg_file, mem_to_inst_reg, mem_to_decode;
   logic       b_to_mem_addr, vector_to_pc, irq_ack, illegal_op, bus_fault;

   mc_control #(.TIMEOUT(4), .IRQ_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .op(op), .ext(ext), .cond_p(cond_p),
      .mem_ready(mem_ready), .irq(irq),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .reg_file_wr_en(reg_file_wr_en),
      .reg_file_a_rd_en(reg_file_a_rd_en), .reg_file_b_rd_en(reg_file_b_rd_en),
      .set_flags(set_flags), .imm_to_b(imm_to_b), .pc_op(pc_op),
      .pc_to_reg_file(pc_to_reg_file), .mem_to_reg_file(mem_to_reg_file),
      .mem_to_inst_reg(mem_to_inst_reg), .mem_to_decode(mem_to_decode),
      .b_to_mem_addr(b_to_mem_addr), .vector_to_pc(vector_to_pc),
      .irq_ack(irq_ack), .illegal_op(illegal_op), .bus_fault(bus_fault)
   );

   always #5 clk = ~clk;

   // Output vector bit masks (MSB first in the same order as act below).
   localparam logic [17:0] MRD  = 18'd1 << 17;
   localparam logic [17:0] MWR  = 18'd1 << 16;
   localparam logic [17:0] RFW  = 18'd1 << 15;
   localparam logic [17:0] ARD  = 18'd1 << 14;
   localparam logic [17:0] BRD  = 18'd1 << 13;
   localparam logic [17:0] FLG  = 18'd1 << 12;
   localparam logic [17:0] IMM  = 18'd1 << 11;
   localparam logic [17:0] PC1  = 18'd1 << 9;
   localparam logic [17:0] PC2  = 18'd2 << 9;
   localparam logic [17:0] PC3  = 18'd3 << 9;
   localparam logic [17:0] P2RF = 18'd1 << 8;
   localparam logic [17:0] M2RF = 18'd1 << 7;
   localparam logic [17:0] M2IR = 18'd1 << 6;
   localparam logic [17:0] M2DC = 18'd1 << 5;
   localparam logic [17:0] B2A  = 18'd1 << 4;
   localparam logic [17:0] VEC  = 18'd1 << 3;
   localparam logic [17:0] ACK  = 18'd1 << 2;
   localparam logic [17:0] ILL  = 18'd1 << 1;
   localparam logic [17:0] FLT  = 18'd1 << 0;

   // Expected output vector of each state.
   localparam logic [17:0] E_FETCH = MRD;
   localparam logic [17:0] E_DEC   = M2IR | M2DC | PC1;
   localparam logic [17:0] E_LAB   = ARD | BRD;
   localparam logic [17:0] E_LA    = ARD;
   localparam logic [17:0] E_LB    = BRD;
   localparam logic [17:0] E_IALU  = IMM | FLG | RFW;
   localparam logic [17:0] E_ALU   = FLG | RFW;
   localparam logic [17:0] E_ALUF  = FLG;
   localparam logic [17:0] E_IALUF = IMM | FLG;
   localparam logic [17:0] E_BR    = IMM | PC2;
   localparam logic [17:0] E_LDM   = B2A | MRD;
   localparam logic [17:0] E_M2RF  = M2RF | RFW;
   localparam logic [17:0] E_ST    = B2A | MWR;
   localparam logic [17:0] E_J     = PC3;
   localparam logic [17:0] E_JAL   = PC3 | P2RF | RFW;
   localparam logic [17:0] E_ILL   = ILL;
   localparam logic [17:0] E_IS    = P2RF | RFW;
   localparam logic [17:0] E_IV    = VEC | PC3 | ACK;
   localparam logic [17:0] E_FLT   = FLT;

   logic [17:0] act;
   assign act = {mem_rd_en, mem_wr_en, reg_file_wr_en, reg_file_a_rd_en,
                 reg_file_b_rd_en, set_flags, imm_to_b, pc_op, pc_to_reg_file,
                 mem_to_reg_file, mem_to_inst_reg, mem_to_decode, b_to_mem_addr,
                 vector_to_pc, irq_ack, illegal_op, bus_fault};

   logic [17:0] exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Queue the expectation for the next rising edge, then move to the next drive point.
   task automatic tick(input logic [17:0] ex, input string nm);
      exp_q.push_back(ex);
      name_q.push_back(nm);
      @(negedge clk);
      #1;
   endtask

   task automatic set_inst(input logic [3:0] o, input logic [3:0] x, input logic c);
      op     = o;
      ext    = x;
      cond_p = c;
   endtask

   // Monitor: compare every pending expectation on the falling edge.
   initial begin
      logic [17:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL %s: got %b expected %b", nm, act, e);
         end
      end
   end

   // Directed stimulus.
   initial begin
      rst_n = 1'b0; en = 1'b0; mem_ready = 1'b1; irq = 1'b0;
      set_inst(4'b0000, 4'b0101, 1'b0);
      @(negedge clk); #1;
      tick(E_FETCH, "reset");
      rst_n = 1'b1; en = 1'b1;

      // ADD, zero-wait memory
      tick(E_DEC, "add_dec"); tick(E_LAB, "add_lab"); tick(E_ALU, "add_alu"); tick(E_FETCH, "add_end");

      // LOAD with three wait cycles
      set_inst(4'b0100, 4'b0000, 1'b0);
      tick(E_DEC, "ld_dec"); tick(E_LB, "ld_lb"); tick(E_LDM, "ld_mem0");
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick(E_LDM, "ld_wait");
      mem_ready = 1'b1;
      tick(E_M2RF, "ld_m2rf"); tick(E_FETCH, "ld_end");

      // BCOND not taken, then taken
      set_inst(4'b1100, 4'b0000, 1'b0);
      tick(E_DEC, "bc_nt_dec"); tick(E_FETCH, "bc_nt_end");
      set_inst(4'b1100, 4'b0000, 1'b1);
      tick(E_DEC, "bc_t_dec"); tick(E_BR, "bc_t_br"); tick(E_FETCH, "bc_t_end");

      // Illegal SPECIAL ext
      set_inst(4'b0100, 4'b0011, 1'b0);
      tick(E_DEC, "ill_dec"); tick(E_ILL, "ill_pulse"); tick(E_FETCH, "ill_end");

      // CMPI, MOVI, CMP, MOV
      set_inst(4'b1011, 4'b0000, 1'b0);
      tick(E_DEC, "cmpi_dec"); tick(E_LA, "cmpi_la"); tick(E_IALUF, "cmpi_ex"); tick(E_FETCH, "cmpi_end");
      set_inst(4'b1101, 4'b0000, 1'b0);
      tick(E_DEC, "movi_dec"); tick(E_IALU, "movi_ex"); tick(E_FETCH, "movi_end");
      set_inst(4'b0000, 4'b1011, 1'b0);
      tick(E_DEC, "cmp_dec"); tick(E_LAB, "cmp_lab"); tick(E_ALUF, "cmp_ex"); tick(E_FETCH, "cmp_end");
      set_inst(4'b0000, 4'b1101, 1'b0);
      tick(E_DEC, "mov_dec"); tick(E_LB, "mov_lb"); tick(E_ALU, "mov_ex"); tick(E_FETCH, "mov_end");

      // SHIFT with LSH and with another ext
      set_inst(4'b1000, 4'b0100, 1'b0);
      tick(E_DEC, "lsh_dec"); tick(E_LAB, "lsh_lab"); tick(E_ALU, "lsh_ex"); tick(E_FETCH, "lsh_end");
      set_inst(4'b1000, 4'b0000, 1'b0);
      tick(E_DEC, "sh_dec"); tick(E_LA, "sh_la"); tick(E_IALU, "sh_ex"); tick(E_FETCH, "sh_end");

      // STORE, zero wait
      set_inst(4'b0100, 4'b0100, 1'b0);
      tick(E_DEC, "st_dec"); tick(E_LAB, "st_lab"); tick(E_ST, "st_mem"); tick(E_FETCH, "st_end");

      // irq raised mid-instruction: instruction completes, then interrupt entry
      set_inst(4'b0000, 4'b0101, 1'b0);
      tick(E_DEC, "irq_dec");
      irq = 1'b1;
      tick(E_LAB, "irq_lab"); tick(E_ALU, "irq_alu"); tick(E_IS, "irq_save");
      tick(E_IV, "irq_vec"); tick(E_FETCH, "irq_fetch");
      // second irq ignored while in service
      tick(E_DEC, "irq2_dec"); tick(E_LAB, "irq2_lab"); tick(E_ALU, "irq2_alu"); tick(E_FETCH, "irq2_ignored");
      // taken JCOND (return) re-enables interrupts
      set_inst(4'b0100, 4'b1100, 1'b1);
      tick(E_DEC, "ret_dec"); tick(E_LB, "ret_lb"); tick(E_J, "ret_jump");
      tick(E_IS, "ret_irq_save"); tick(E_IV, "ret_irq_vec"); tick(E_FETCH, "ret_fetch");
      irq = 1'b0;
      tick(E_DEC, "ret2_dec"); tick(E_LB, "ret2_lb"); tick(E_J, "ret2_jump"); tick(E_FETCH, "ret2_end");
      // in_irq cleared: an irq at the end of MOVI is taken
      set_inst(4'b1101, 4'b0000, 1'b0);
      irq = 1'b1;
      tick(E_DEC, "irq3_dec"); tick(E_IALU, "irq3_ex"); tick(E_IS, "irq3_save");
      irq = 1'b0;
      tick(E_IV, "irq3_vec"); tick(E_FETCH, "irq3_fetch");
      set_inst(4'b0100, 4'b1100, 1'b1);
      tick(E_DEC, "ret3_dec"); tick(E_LB, "ret3_lb"); tick(E_J, "ret3_jump"); tick(E_FETCH, "ret3_end");
      // JCOND not taken, JAL
      set_inst(4'b0100, 4'b1100, 1'b0);
      tick(E_DEC, "jc_nt_dec"); tick(E_FETCH, "jc_nt_end");
      set_inst(4'b0100, 4'b1000, 1'b0);
      tick(E_DEC, "jal_dec"); tick(E_LB, "jal_lb"); tick(E_JAL, "jal_ex"); tick(E_FETCH, "jal_end");

      // en low in LOAD_B and during memory wait: state and counter hold
      set_inst(4'b0100, 4'b0000, 1'b0);
      tick(E_DEC, "en_dec"); tick(E_LB, "en_lb");
      en = 1'b0; mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick(E_LB, "en_hold_lb");
      en = 1'b1;
      tick(E_LDM, "en_ldm");
      tick(E_LDM, "en_wait1"); tick(E_LDM, "en_wait2");
      en = 1'b0;
      for (int i = 0; i < 3; i++) tick(E_LDM, "en_hold_ldm");
      en = 1'b1;
      tick(E_LDM, "en_wait3");
      mem_ready = 1'b1;
      tick(E_M2RF, "en_m2rf"); tick(E_FETCH, "en_end");

      // reset mid-store aborts the write
      set_inst(4'b0100, 4'b0100, 1'b0);
      tick(E_DEC, "rs_dec"); tick(E_LAB, "rs_lab"); tick(E_ST, "rs_st");
      mem_ready = 1'b0;
      tick(E_ST, "rs_wait");
      rst_n = 1'b0;
      tick(E_FETCH, "rs_abort");
      rst_n = 1'b1;

      // bus timeout in FETCH, sticky FAULT, reset recovery
      for (int i = 0; i < 3; i++) tick(E_FETCH, "to_wait");
      tick(E_FLT, "to_fault");
      mem_ready = 1'b1;
      tick(E_FLT, "fault_sticky1");
      irq = 1'b1;
      tick(E_FLT, "fault_sticky2");
      irq = 1'b0;
      rst_n = 1'b0;
      tick(E_FETCH, "fault_reset");
      rst_n = 1'b1;
      set_inst(4'b0000, 4'b0101, 1'b0);
      tick(E_DEC, "post_dec"); tick(E_LAB, "post_lab"); tick(E_ALU, "post_alu"); tick(E_FETCH, "post_end");

      @(negedge clk); #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum mem_ready wait cycles before bus fault; range 1-255.
REQ-002 Parameter IRQ_EN, default 1: 1 enables interrupt entry; 0 makes irq ignored.
REQ-003 Ports (name, direction, width, meaning), in this order:
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- en in 1: global advance enable.
- op in 4: instruction [15:12].
- ext in 4: instruction [7:4].
- cond_p in 1: condition true.
- mem_ready in 1: memory transfer complete.
- irq in 1: level interrupt request.
REQ-004 Output ports, all out 1 unless stated: mem_rd_en, mem_wr_en, reg_file_wr_en, reg_file_a_rd_en, reg_file_b_rd_en, set_flags, imm_to_b, pc_op (out 2: 0 hold, 1 increment, 2 add displacement, 3 load target), pc_to_reg_file, mem_to_reg_file, mem_to_inst_reg, mem_to_decode, b_to_mem_addr, vector_to_pc, irq_ack, illegal_op, bus_fault.

Function
REQ-005 Opcode and ext encodings are fixed:
- op: BCOND=1100, CMPI=1011, MOVI=1101, REGISTER=0000, SHIFT=1000, SPECIAL=0100; any other op is an immediate ALU op.
- ext: CMP=1011, JCOND=1100, JAL=1000, LSH=0100, LOAD=0000, MOV=1101, STORE=0100.
REQ-006 State register SHALL update only on clk edges where en=1; the wait counter SHALL also hold when en=0.
REQ-007 All outputs SHALL be Moore, decoded from state only, and default to 0.
REQ-008 States and outputs:
- FETCH: mem_rd_en.
- DECODE: mem_to_inst_reg, mem_to_decode, pc_op=1.
- LOAD_A_B: a_rd, b_rd. LOAD_A: a_rd. LOAD_B: b_rd.
- IMM_ALU_OP: imm_to_b, set_flags, reg_file_wr_en.
- ALU_OP: set_flags, reg_file_wr_en.
- ALU_FLAG_OP: set_flags. IMM_ALU_FLAG_OP: imm_to_b, set_flags.
- BRANCH: imm_to_b, pc_op=2.
- LOAD_FROM_MEM: b_to_mem_addr, mem_rd_en.
- MEM_TO_REG_FILE: mem_to_reg_file, reg_file_wr_en.
- STORE_TO_MEM: b_to_mem_addr, mem_wr_en.
- JUMP: pc_op=3.
- JUMP_AND_LINK: pc_op=3, pc_to_reg_file, reg_file_wr_en.
- ILLEGAL: illegal_op.
- IRQ_SAVE: pc_to_reg_file, reg_file_wr_en.
- IRQ_VECTOR: vector_to_pc, pc_op=3, irq_ack.
- FAULT: bus_fault.
REQ-009 DECODE transitions:
- BCOND: BRANCH if cond_p, else END.
- MOVI: IMM_ALU_OP.
- REGISTER: LOAD_B if ext=MOV, else LOAD_A_B.
- SHIFT: LOAD_A_B if ext=LSH, else LOAD_A.
- SPECIAL: JAL→LOAD_B; JCOND→LOAD_B if cond_p, else END; LOAD→LOAD_B; STORE→LOAD_A_B; other ext→ILLEGAL.
- Other op: LOAD_A.
REQ-010 Operand-load transitions:
- LOAD_A_B: STORE_TO_MEM if op=SPECIAL; else ALU_FLAG_OP if ext=CMP; else ALU_OP.
- LOAD_A: IMM_ALU_FLAG_OP if op=CMPI, else IMM_ALU_OP.
- LOAD_B: ALU_OP if op=REGISTER; else JUMP_AND_LINK for JAL, JUMP for JCOND, LOAD_FROM_MEM for LOAD.
REQ-011 Memory states (FETCH, LOAD_FROM_MEM, STORE_TO_MEM) SHALL hold, with strobes asserted, until mem_ready=1 is sampled.
- On ready: FETCH→DECODE, LOAD_FROM_MEM→MEM_TO_REG_FILE, STORE_TO_MEM→END.
- Zero-wait case: mem_ready=1 in the first cycle advances immediately.
REQ-012 An 8-bit wait counter SHALL clear on entry to each memory state and increment each waiting cycle. If the count reaches TIMEOUT without mem_ready, the FSM SHALL enter FAULT.
REQ-013 FAULT is sticky: bus_fault=1 until reset; no other output is asserted.
REQ-014 ILLEGAL lasts one cycle, then goes to END.
REQ-015 END is the transition out of any terminal state (execute, BRANCH, JUMP, JUMP_AND_LINK, MEM_TO_REG_FILE, ILLEGAL, or a not-taken branch/jump):
- IRQ_SAVE if IRQ_EN=1, irq=1 and in_irq=0.
- Otherwise FETCH.
REQ-016 Interrupt sequence: IRQ_SAVE→IRQ_VECTOR→FETCH. in_irq sets on leaving IRQ_VECTOR.
REQ-017 in_irq SHALL clear on leaving JUMP (interrupt return) and when JUMP is entered with in_irq=1.
REQ-018 irq SHALL be sampled only at END; irq asserted mid-instruction SHALL NOT alter that instruction.
REQ-019 Unencoded state values SHALL return to FETCH.

Reset
REQ-020 rst_n=0 SHALL immediately force state=FETCH, counter=0 and in_irq=0. mem_rd_en=1 follows from FETCH; all other outputs are 0, including bus_fault.
REQ-021 Reset asserted mid-transfer or in FAULT SHALL abort that activity; no write strobe may be asserted after reset.

Verification
REQ-022 ADD (op 0000, ext 0101), mem_ready=1 throughout:
- FETCH, DECODE, LOAD_A_B, ALU_OP, FETCH over 4 cycles.
- reg_file_wr_en=1 only in ALU_OP.
REQ-023 LOAD (op 0100, ext 0000) with mem_ready low for 3 cycles in LOAD_FROM_MEM:
- mem_rd_en and b_to_mem_addr held for 4 cycles.
- Then MEM_TO_REG_FILE with mem_to_reg_file=1.
REQ-024 TIMEOUT=4, mem_ready held 0 in FETCH:
- FAULT entered after 4 wait cycles; bus_fault=1 stays set.
- rst_n pulse returns the FSM to FETCH with bus_fault=0.
REQ-025 irq=1 during an ALU_OP instruction:
- Instruction completes, then IRQ_SAVE (pc_to_reg_file=1), then IRQ_VECTOR (irq_ack=1 for one cycle), then FETCH.
- A second irq is ignored until a taken JCOND reaches JUMP.
REQ-026 SPECIAL with ext 0011 → illegal_op pulses one cycle. BCOND with cond_p=0 → DECODE goes directly to FETCH with pc_op=0.
REQ-027 en=0 for 5 cycles in LOAD_B → state and counter hold and outputs stay constant; operation resumes on en=1.
